// File: rtl/req_gnt_pkg.sv
// req_gnt_pkg: shared arbiter state encoding and one-hot helper
//   arb_state_e : ARB_IDLE (no owner) / ARB_GRANT (one owner holds gnt)
//   onehot      : 32-bit one-hot of idx, all-zero when idx >= n
package req_gnt_pkg;
    typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_e;
    function automatic logic [31:0] onehot(input int unsigned idx, input int unsigned n);
        return (idx < n) ? (32'd1 << idx) : 32'd0;
    endfunction
endpackage

// File: rtl/req_gnt_rr_arbiter_if.sv
// req_gnt_rr_arbiter_if: request/grant bundle between requesters and the arbiter
//   req       : one level-sensitive request per port (requester -> arbiter)
//   gnt       : registered one-hot-or-zero grant (arbiter -> requester)
//   gnt_valid : |gnt
//   gnt_idx   : owner index, 0 when no grant
//   master = requester side, slave = arbiter side
interface req_gnt_rr_arbiter_if #(
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]         req;
    logic [N_REQ-1:0]         gnt;
    logic                     gnt_valid;
    logic [$clog2(N_REQ)-1:0] gnt_idx;
    modport master (output req, input gnt, input gnt_valid, input gnt_idx);
    modport slave  (input req, output gnt, output gnt_valid, output gnt_idx);
endinterface

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: combinational rotating-priority search
//   req_mask : candidate requests
//   base     : index with highest priority; search wraps N_REQ-1 -> 0
//   found    : any candidate set
//   idx      : first set candidate at or after base (0 when none)
module rr_priority_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req_mask,
    input  logic [$clog2(N_REQ)-1:0] base,
    output logic                     found,
    output logic [$clog2(N_REQ)-1:0] idx
);
    localparam int IDX_W = $clog2(N_REQ);
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] cand_idx;
    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = '0;
        cand_idx = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, base} + (IDX_W + 1)'(k);
            // Explicit wrap so non power-of-two N_REQ never relies on overflow.
            if (cand >= (IDX_W + 1)'(N_REQ)) cand = cand - (IDX_W + 1)'(N_REQ);
            cand_idx = cand[IDX_W-1:0];
            if (req_mask[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end
endmodule

// File: rtl/req_gnt_rr_arbiter.sv
// req_gnt_rr_arbiter: registered round-robin arbiter with bounded hold under contention
//   clk : clock, all state on posedge
//   res : synchronous active-high reset
//   bus : slave side of req_gnt_rr_arbiter_if (req in; gnt, gnt_valid, gnt_idx out)
module req_gnt_rr_arbiter
    import req_gnt_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int MAX_HOLD = 8
) (
    input logic               clk,
    input logic               res,
    req_gnt_rr_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int HC_W  = $clog2(MAX_HOLD) + 1;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic [31:0]      own_oh_w, pick_oh_w;
    logic [N_REQ-1:0] own_mask, pick_mask;
    logic [IDX_W-1:0] next_owner, pick_base, pick_idx;
    logic             pick_found, own_req, hold_max, hand_over;

    assign own_oh_w   = onehot(32'(owner_q), N_REQ);
    assign own_mask   = own_oh_w[N_REQ-1:0];
    assign next_owner = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
    // One search serves both cases: all requests from rr_ptr when idle,
    // everyone but the owner starting just after it when granted.
    assign pick_mask  = (state_q == ARB_GRANT) ? (bus.req & ~own_mask) : bus.req;
    assign pick_base  = (state_q == ARB_GRANT) ? next_owner : rr_ptr_q;
    assign pick_oh_w  = onehot(32'(pick_idx), N_REQ);
    assign own_req    = bus.req[owner_q];
    assign hold_max   = (hold_cnt_q == HC_W'(MAX_HOLD - 1));
    // In GRANT, pick_found means another requester is waiting.
    assign hand_over  = pick_found && (!own_req || hold_max);

    rr_priority_pick #(.N_REQ(N_REQ)) u_pick (
        .req_mask (pick_mask),
        .base     (pick_base),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        hold_cnt_d = hold_cnt_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        if (state_q == ARB_IDLE) begin
            if (pick_found) begin
                state_d    = ARB_GRANT;
                owner_d    = pick_idx;
                gnt_d      = pick_oh_w[N_REQ-1:0];
                hold_cnt_d = '0;
            end
        end else if (hand_over) begin
            owner_d    = pick_idx;
            gnt_d      = pick_oh_w[N_REQ-1:0];
            hold_cnt_d = '0;
            rr_ptr_d   = next_owner;
        end else if (!own_req) begin
            state_d    = ARB_IDLE;
            owner_d    = '0;
            gnt_d      = '0;
            hold_cnt_d = '0;
            rr_ptr_d   = next_owner;
        end else begin
            hold_cnt_d = hold_max ? hold_cnt_q : hold_cnt_q + 1'b1;
        end
        gnt_valid_d = (state_d == ARB_GRANT);
    end

    always_ff @(posedge clk) begin
        if (res) begin
            state_q     <= ARB_IDLE;
            rr_ptr_q    <= '0;
            hold_cnt_q  <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    // owner_q is cleared on release, so it doubles as gnt_idx.
    assign bus.gnt       = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_idx   = owner_q;
endmodule
